fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter PC_W, default 9: width of all PC/address fields.
REQ-002 Parameter INS_W, default 32: instruction width.
REQ-003 Parameter DEPTH, default 4: queue entries, power of two, at least 2.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: reset is synchronous and active-high.
REQ-006 Port imem_req, output, 1: instruction-memory read request this cycle.
REQ-007 Port imem_addr, output, PC_W: byte address of the request.
REQ-008 Port imem_rdata, input, INS_W: read data, valid exactly one cycle after the cycle imem_req=1.
REQ-009 Port redirect, input, 1: branch/jump taken (PcSel); flush and refetch.
REQ-010 Port redirect_pc, input, PC_W: target address, sampled when redirect=1.
REQ-011 Port halt_req, input, 1: HALT decoded; stop fetching.
REQ-012 Port deq_ready, input, 1: IF/ID stage accepts an entry (not stalled, not halted).
REQ-013 Port deq_valid, output, 1: head entry valid.
REQ-014 Port deq_pc, output, PC_W: PC of the head entry.
REQ-015 Port deq_instr, output, INS_W: instruction of the head entry.
REQ-016 Port halted, output, 1: fetch is in the HALTED state.
REQ-017 Port occupancy, output, clog2(DEPTH)+1: current number of valid entries.

Function
REQ-018 The block SHALL implement two states, FETCH and HALTED; the only exit from HALTED SHALL be reset.
REQ-019 Transitions: FETCH->HALTED on halt_req=1 while redirect=0; redirect=1 in the same cycle SHALL take priority, and the block SHALL stay in FETCH.
REQ-020 The block SHALL hold a fetch_pc register; each issued request SHALL use imem_addr=fetch_pc, then fetch_pc+=4 modulo 2^PC_W (508->0 for PC_W=9).
REQ-021 Issue rule: imem_req=1 only when all of the following hold: state=FETCH, redirect=0, halt_req=0, and occupancy + inflight < DEPTH, where occupancy and inflight are the registered current-cycle values and inflight is the 1-bit outstanding-request flag.
REQ-022 Credit check SHALL NOT count a dequeue in the same cycle, so the queue never overflows.
REQ-023 A response SHALL be written at the tail, with the PC captured at issue, at the end of the cycle it arrives, unless it is discarded (REQ-025).
REQ-024 The queue SHALL NOT bypass: the earliest deq_valid for a response is the cycle after it arrives.
REQ-025 On redirect=1 the block SHALL empty the queue, discard any response arriving in that cycle or the next, set fetch_pc=redirect_pc, and issue no request that cycle.
REQ-026 The first post-redirect request SHALL be in cycle N+1 at redirect_pc, and deq_valid for it SHALL rise in cycle N+3.
REQ-027 Dequeue SHALL occur when deq_valid=1 and deq_ready=1; the head advances and occupancy decrements.
REQ-028 A simultaneous enqueue and dequeue SHALL leave occupancy unchanged.
REQ-029 A dequeue in the same cycle as redirect SHALL be ignored, since the flush wins.
REQ-030 In HALTED, no request SHALL be issued; an in-flight response SHALL still be enqueued; dequeue SHALL continue until empty.
REQ-031 Head/tail pointers SHALL wrap modulo DEPTH.
REQ-032 deq_pc and deq_instr SHALL be driven from the head entry; their value SHALL be don't-care when deq_valid=0.

Reset
REQ-033 On reset=1 at a clock edge, the following SHALL be cleared: state=FETCH, fetch_pc=0, occupancy=0, inflight=0, the discard flag, and the pointers.
REQ-034 During reset cycles, outputs SHALL be: imem_req=0, deq_valid=0, halted=0.
REQ-035 A reset asserted mid-operation SHALL drop queued entries and any in-flight response.
REQ-036 A response arriving in the first post-reset cycle SHALL be ignored.
REQ-037 With reset deasserted at edge E, the first request SHALL be issued at address 0 in the cycle following E.

Verification
REQ-038 Reset release, deq_ready=0, imem returns instr=addr: requests 0,4,8,12, then imem_req stays 0; occupancy=4.
REQ-039 Full queue, then deq_ready=1 continuously: one dequeue per cycle, with deq_pc sequence 0,4,8,12,16,...; no gaps after steady state; occupancy never exceeds 4.
REQ-040 Redirect to 0x100 with 3 entries queued and a request in flight: occupancy=0 the next cycle; the in-flight data is never dequeued; the next request is at 0x100; deq_pc=0x100 appears 3 cycles after the redirect.
REQ-041 fetch_pc=508: requests issue at 508 then 0; deq_pc shows 508, then 0.
REQ-042 halt_req pulse with one request in flight: halted=1 next cycle; the in-flight entry is enqueued and dequeued; imem_req stays 0; a later redirect is ignored.
REQ-043 redirect and halt_req in the same cycle: halted stays 0; fetching resumes at redirect_pc.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch unit with a small in-order queue.
// Issues one read per cycle under credit control; flushes on redirect.
module fetch_queue #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [PC_W-1:0]            imem_addr,
  input  logic [INS_W-1:0]           imem_rdata,
  input  logic                       redirect,
  input  logic [PC_W-1:0]            redirect_pc,
  input  logic                       halt_req,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [PC_W-1:0]            deq_pc,
  output logic [INS_W-1:0]           deq_instr,
  output logic                       halted,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW:0] DEPTH_C = (OW+1)'(DEPTH);

  typedef enum logic {
    S_FETCH  = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PC_W-1:0]  r_fetch_pc;
  logic [PC_W-1:0]  r_req_pc;
  logic             r_inflight;
  logic             r_discard;
  logic [OW-1:0]    r_occ;
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [PC_W-1:0]  r_pc_q  [DEPTH];
  logic [INS_W-1:0] r_ins_q [DEPTH];

  logic             w_fetching;
  logic             w_redir;
  logic [OW:0]      w_used;
  logic             w_credit;
  logic             w_issue;
  logic             w_enq;
  logic             w_deq;
  logic             w_deq_valid;

  // Redirects only matter while fetching; HALTED is left by reset alone.
  assign w_fetching  = (r_state == S_FETCH);
  assign w_redir     = redirect && w_fetching;
  // Credit ignores a same-cycle dequeue so the queue can never overflow.
  assign w_used      = {1'b0, r_occ} + {{OW{1'b0}}, r_inflight};
  assign w_credit    = (w_used < DEPTH_C);
  assign w_issue     = w_fetching && !redirect && !halt_req && w_credit;
  assign w_deq_valid = (r_occ != '0);
  assign w_enq       = r_inflight && !r_discard && !w_redir;
  assign w_deq       = w_deq_valid && deq_ready && !w_redir;

  assign imem_req    = !reset && w_issue;
  assign imem_addr   = r_fetch_pc;
  assign deq_valid   = !reset && w_deq_valid;
  assign deq_pc      = r_pc_q[r_head];
  assign deq_instr   = r_ins_q[r_head];
  assign halted      = !reset && !w_fetching;
  assign occupancy   = r_occ;

  // State register for the FETCH/HALTED machine.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_state_nxt;
  end

  // Halt is taken only when no redirect competes in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_FETCH:  if (halt_req && !redirect) w_state_nxt = S_HALTED;
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_FETCH;
    endcase
  end

  // Fetch PC, outstanding-request tracking and response discard window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= '0;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_discard  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_discard  <= w_redir;
      if (w_redir) begin
        r_fetch_pc <= redirect_pc;
      end else if (w_issue) begin
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + PC_W'(4);
      end
    end
  end

  // Queue pointers and occupancy; a redirect flush overrides both ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else if (w_redir) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + AW'(1);
      if (w_deq) r_head <= r_head + AW'(1);
      unique case ({w_enq, w_deq})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Entry storage, written at the tail with the PC captured at issue.
  always_ff @(posedge clk) begin
    if (w_enq && !reset) begin
      r_pc_q[r_tail]  <= r_req_pc;
      r_ins_q[r_tail] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed cycle table plus a random-backpressure in-order scoreboard.
// Instruction memory model returns the request address as data.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [8:0]  redirect_pc = '0;
  logic        halt_req = 1'b0;
  logic        deq_ready = 1'b0;
  logic        deq_valid;
  logic [8:0]  deq_pc;
  logic [31:0] deq_instr;
  logic        halted;
  logic [2:0]  occupancy;

  int n_pass = 0;
  int n_tot  = 0;

  fetch_queue #(.PC_W(9), .INS_W(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .deq_ready(deq_ready),
    .deq_valid(deq_valid), .deq_pc(deq_pc),
    .deq_instr(deq_instr), .halted(halted),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Memory answers one cycle after each request.
  always @(posedge clk)
    if (imem_req) imem_rdata <= {23'd0, imem_addr};

  typedef struct {
    logic       rst, rd;
    logic [8:0] rpc;
    logic       hlt, dr;
    logic       req;
    logic [8:0] addr;
    logic       dv;
    logic [8:0] dpc;
    logic       h;
    logic [2:0] occ;
    logic       co;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(
    logic rst, logic rd, logic [8:0] rpc, logic hlt, logic dr,
    logic req, logic [8:0] addr, logic dv, logic [8:0] dpc,
    logic h, logic [2:0] occ, logic co);
    vec_t t;
    t.rst = rst; t.rd = rd; t.rpc = rpc; t.hlt = hlt; t.dr = dr;
    t.req = req; t.addr = addr; t.dv = dv; t.dpc = dpc;
    t.h = h; t.occ = occ; t.co = co;
    return t;
  endfunction

  task automatic chk(string nm, int row, logic [31:0] act,
                     logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %0h expected %0h",
                  nm, row, act, exp);
  endtask

  initial begin
    logic [8:0] exp_pc;
    int ndeq;
    //       rst rd rpc hlt dr  req addr dv dpc h occ co
    v.push_back(mk(1,0,0,  0,0, 0,0,  0,0,  0,0,0));
    v.push_back(mk(1,0,0,  0,0, 0,0,  0,0,  0,0,1));
    v.push_back(mk(0,0,0,  0,0, 1,0,  0,0,  0,0,1));
    v.push_back(mk(0,0,0,  0,0, 1,4,  0,0,  0,0,1));
    v.push_back(mk(0,0,0,  0,0, 1,8,  1,0,  0,1,1));
    v.push_back(mk(0,0,0,  0,0, 1,12, 1,0,  0,2,1));
    v.push_back(mk(0,0,0,  0,0, 0,0,  1,0,  0,3,1));
    v.push_back(mk(0,0,0,  0,0, 0,0,  1,0,  0,4,1));
    v.push_back(mk(0,0,0,  0,1, 0,0,  1,0,  0,4,1));
    v.push_back(mk(0,0,0,  0,1, 1,16, 1,4,  0,3,1));
    v.push_back(mk(0,0,0,  0,1, 1,20, 1,8,  0,2,1));
    v.push_back(mk(0,0,0,  0,1, 1,24, 1,12, 0,2,1));
    v.push_back(mk(0,0,0,  0,1, 1,28, 1,16, 0,2,1));
    v.push_back(mk(0,0,0,  0,1, 1,32, 1,20, 0,2,1));
    v.push_back(mk(0,0,0,  0,0, 1,36, 1,24, 0,2,1));
    v.push_back(mk(0,1,256,0,1, 0,0,  1,24, 0,3,1));
    v.push_back(mk(0,0,0,  0,1, 1,256,0,0,  0,0,1));
    v.push_back(mk(0,0,0,  0,1, 1,260,0,0,  0,0,1));
    v.push_back(mk(0,0,0,  0,1, 1,264,1,256,0,1,1));
    v.push_back(mk(0,0,0,  0,1, 1,268,1,260,0,1,1));
    v.push_back(mk(0,1,508,0,1, 0,0,  1,264,0,1,1));
    v.push_back(mk(0,0,0,  0,1, 1,508,0,0,  0,0,1));
    v.push_back(mk(0,0,0,  0,1, 1,0,  0,0,  0,0,1));
    v.push_back(mk(0,0,0,  0,1, 1,4,  1,508,0,1,1));
    v.push_back(mk(0,0,0,  0,1, 1,8,  1,0,  0,1,1));
    v.push_back(mk(0,0,0,  1,0, 0,0,  1,4,  0,1,1));
    v.push_back(mk(0,0,0,  0,0, 0,0,  1,4,  1,2,1));
    v.push_back(mk(0,1,64, 0,1, 0,0,  1,4,  1,2,1));
    v.push_back(mk(0,0,0,  0,1, 0,0,  1,8,  1,1,1));
    v.push_back(mk(0,0,0,  0,1, 0,0,  0,0,  1,0,1));
    v.push_back(mk(1,0,0,  0,0, 0,0,  0,0,  0,0,1));
    v.push_back(mk(0,0,0,  0,1, 1,0,  0,0,  0,0,1));
    v.push_back(mk(0,1,128,1,1, 0,0,  0,0,  0,0,1));
    v.push_back(mk(0,0,0,  0,1, 1,128,0,0,  0,0,1));
    v.push_back(mk(0,0,0,  0,1, 1,132,0,0,  0,0,1));
    v.push_back(mk(0,0,0,  0,1, 1,136,1,128,0,1,1));
    v.push_back(mk(1,0,0,  0,1, 0,0,  0,0,  0,0,0));
    v.push_back(mk(0,0,0,  0,1, 1,0,  0,0,  0,0,1));
    v.push_back(mk(0,0,0,  0,1, 1,4,  0,0,  0,0,1));
    v.push_back(mk(0,0,0,  0,1, 1,8,  1,0,  0,1,1));

    foreach (v[i]) begin
      @(posedge clk); #1;
      reset = v[i].rst; redirect = v[i].rd;
      redirect_pc = v[i].rpc; halt_req = v[i].hlt;
      deq_ready = v[i].dr;
      #3;
      chk("imem_req", i, 32'(imem_req), 32'(v[i].req));
      if (v[i].req)
        chk("imem_addr", i, 32'(imem_addr), 32'(v[i].addr));
      chk("deq_valid", i, 32'(deq_valid), 32'(v[i].dv));
      if (v[i].dv) begin
        chk("deq_pc", i, 32'(deq_pc), 32'(v[i].dpc));
        chk("deq_instr", i, deq_instr, 32'(v[i].dpc));
      end
      chk("halted", i, 32'(halted), 32'(v[i].h));
      if (v[i].co)
        chk("occupancy", i, 32'(occupancy), 32'(v[i].occ));
    end

    // Random backpressure: strictly sequential PCs, no overflow.
    @(posedge clk); #1;
    reset = 1'b1; redirect = 1'b0; halt_req = 1'b0;
    deq_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_pc = '0;
    ndeq = 0;
    for (int c = 0; c < 120; c++) begin
      @(posedge clk); #1;
      deq_ready = 1'($urandom_range(0, 1));
      #3;
      chk("occ_max", 1000 + c, 32'(occupancy <= 3'd4), 32'd1);
      if (deq_valid && deq_ready) begin
        chk("sb_pc", 1000 + c, 32'(deq_pc), 32'(exp_pc));
        chk("sb_instr", 1000 + c, deq_instr, 32'(exp_pc));
        exp_pc = exp_pc + 9'd4;
        ndeq++;
      end
    end
    chk("sb_progress", 2000, 32'(ndeq >= 20), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
